// File: rtl/rtc_defs_pkg.sv
// Shared definitions for the DS1302 poll controller: command bit map, write-protect data,
// FSM state encoding, BCD field masks and command decode helpers.
package rtc_defs_pkg;

    localparam int unsigned BitWpOff = 7;
    localparam int unsigned BitWHour = 6;
    localparam int unsigned BitWMin  = 5;
    localparam int unsigned BitWSec  = 4;
    localparam int unsigned BitWpOn  = 3;
    localparam int unsigned BitRHour = 2;
    localparam int unsigned BitRMin  = 1;
    localparam int unsigned BitRSec  = 0;

    localparam logic [7:0] WpOffData = 8'h00;
    localparam logic [7:0] WpOnData  = 8'h80;

    localparam logic [7:0] SecMask  = 8'h7F;
    localparam logic [7:0] MinMask  = 8'h7F;
    localparam logic [7:0] HourMask = 8'h3F;

    typedef enum logic [3:0] {
        StIdle,
        StWpOff,
        StWHour,
        StWMin,
        StWSec,
        StWpOn,
        StRSec,
        StRMin,
        StRHour,
        StRSec2,
        StGap,
        StUpdate
    } state_e;

    // One-hot Start_Sig pattern for a state; zero for non-command states.
    function automatic logic [7:0] cmd_onehot(input state_e st);
        logic [7:0] cmd;
        cmd = '0;
        case (st)
            StWpOff: cmd[BitWpOff] = 1'b1;
            StWHour: cmd[BitWHour] = 1'b1;
            StWMin:  cmd[BitWMin]  = 1'b1;
            StWSec:  cmd[BitWSec]  = 1'b1;
            StWpOn:  cmd[BitWpOn]  = 1'b1;
            StRSec:  cmd[BitRSec]  = 1'b1;
            StRMin:  cmd[BitRMin]  = 1'b1;
            StRHour: cmd[BitRHour] = 1'b1;
            StRSec2: cmd[BitRSec]  = 1'b1;
            default: cmd = '0;
        endcase
        return cmd;
    endfunction

    // Command that follows a completed command in the single-pass flow.
    function automatic state_e next_cmd(input state_e st);
        state_e nxt;
        case (st)
            StWpOff: nxt = StWHour;
            StWHour: nxt = StWMin;
            StWMin:  nxt = StWSec;
            StWSec:  nxt = StWpOn;
            StWpOn:  nxt = StRSec;
            StRSec:  nxt = StRMin;
            StRMin:  nxt = StRHour;
            default: nxt = StUpdate;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rtc_cycle_counter.sv
// Loadable up-counter with a terminal-count flag; used for the poll timer and the
// per-command timeout.
module rtc_cycle_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic             tc_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/rtc_poll_ctrl.sv
// Command sequencer for the DS1302 access block: optional init write, periodic sec/min/hour
// polling, host time-set and a coherent BCD snapshot. RTC_COHERENT_READ_EN adds a seconds re-read.
module rtc_poll_ctrl
    import rtc_defs_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = 5_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 65_535,
    parameter bit          INIT_ON_RESET  = 1'b1,
    parameter logic [7:0]  INIT_HOUR      = 8'h12,
    parameter logic [7:0]  INIT_MIN       = 8'h00,
    parameter logic [7:0]  INIT_SEC       = 8'h00
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Set_Req,
    input  logic [7:0] Set_Hour,
    input  logic [7:0] Set_Min,
    input  logic [7:0] Set_Sec,
    output logic [7:0] Start_Sig,
    input  logic       Done_Sig,
    output logic [7:0] Time_Write_Data,
    input  logic [7:0] Time_Read_Data,
    output logic [7:0] Hour,
    output logic [7:0] Min,
    output logic [7:0] Sec,
    output logic       Time_Valid,
    output logic       Busy,
    output logic       Err
);

    localparam int unsigned PollW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    state_e     nxt;
    logic       start_wr, timeout;
    logic       poll_tc, wait_tc;
    logic       set_pend_q, init_pend_q;
    logic [7:0] set_hour_q, set_min_q, set_sec_q;
    logic [7:0] wr_hour_q, wr_min_q, wr_sec_q;
    logic [7:0] sh_hour_q, sh_min_q, sh_sec_q;
    logic [7:0] start_sig_q, wdata_q, wdata_d;
    logic [7:0] hour_q, min_q, sec_q;
    logic       valid_q, err_q;
`ifdef RTC_COHERENT_READ_EN
    logic       retry_q, retry_d;
`endif

    rtc_cycle_counter #(
        .Width (PollW)
    ) u_poll_cnt (
        .clk_i      (CLK),
        .rst_ni     (RSTn),
        .load_i     (state_d != StIdle),
        .load_val_i ('0),
        .en_i       (state_q == StIdle),
        .term_i     (PollW'(POLL_CYCLES - 1)),
        .tc_o       (poll_tc)
    );

    // Restarts on every state change, so it measures time spent waiting in one command.
    rtc_cycle_counter #(
        .Width (TmoW)
    ) u_wait_cnt (
        .clk_i      (CLK),
        .rst_ni     (RSTn),
        .load_i     (state_d != state_q),
        .load_val_i ('0),
        .en_i       (1'b1),
        .term_i     (TmoW'(TIMEOUT_CYCLES - 1)),
        .tc_o       (wait_tc)
    );

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        nxt      = StIdle;
        start_wr = 1'b0;
        timeout  = 1'b0;
`ifdef RTC_COHERENT_READ_EN
        retry_d  = (state_q == StIdle) ? 1'b0 : retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (set_pend_q || init_pend_q) begin
                    state_d  = StWpOff;
                    start_wr = 1'b1;
                end else if (poll_tc) begin
                    state_d = StRSec;
                end
            end
            StGap:    state_d = ret_q;
            StUpdate: state_d = StIdle;
            default: begin
                if (Done_Sig) begin
                    nxt = next_cmd(state_q);
`ifdef RTC_COHERENT_READ_EN
                    if (state_q == StRHour) begin
                        nxt = StRSec2;
                    end else if (state_q == StRSec2 && !retry_q &&
                                 (Time_Read_Data & SecMask) < (sh_sec_q & SecMask)) begin
                        nxt     = StRSec;
                        retry_d = 1'b1;
                    end
`endif
                    if (nxt == StUpdate) begin
                        state_d = StUpdate;
                    end else begin
                        state_d = StGap;
                        ret_d   = nxt;
                    end
                end else if (wait_tc) begin
                    state_d = StIdle;
                    timeout = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        wdata_d = 8'h00;
        case (state_d)
            StWpOff: wdata_d = WpOffData;
            StWHour: wdata_d = wr_hour_q;
            StWMin:  wdata_d = wr_min_q;
            StWSec:  wdata_d = wr_sec_q;
            StWpOn:  wdata_d = WpOnData;
            default: wdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= StIdle;
            ret_q       <= StIdle;
            set_pend_q  <= 1'b0;
            init_pend_q <= INIT_ON_RESET;
            set_hour_q  <= '0;
            set_min_q   <= '0;
            set_sec_q   <= '0;
            wr_hour_q   <= '0;
            wr_min_q    <= '0;
            wr_sec_q    <= '0;
            sh_hour_q   <= '0;
            sh_min_q    <= '0;
            sh_sec_q    <= '0;
            start_sig_q <= '0;
            wdata_q     <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef RTC_COHERENT_READ_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            start_sig_q <= cmd_onehot(state_d);
            wdata_q     <= wdata_d;
`ifdef RTC_COHERENT_READ_EN
            retry_q     <= retry_d;
`endif
            // A request arriving while a sequence starts stays pending for the next one.
            set_pend_q <= Set_Req | (set_pend_q & ~start_wr);
            if (Set_Req) begin
                set_hour_q <= Set_Hour;
                set_min_q  <= Set_Min;
                set_sec_q  <= Set_Sec;
            end
            if (start_wr) begin
                init_pend_q <= 1'b0;
                wr_hour_q   <= set_pend_q ? set_hour_q : INIT_HOUR;
                wr_min_q    <= set_pend_q ? set_min_q  : INIT_MIN;
                wr_sec_q    <= set_pend_q ? set_sec_q  : INIT_SEC;
            end
            if (Done_Sig) begin
                case (state_q)
                    StRSec:  sh_sec_q  <= Time_Read_Data;
                    StRMin:  sh_min_q  <= Time_Read_Data;
                    StRHour: sh_hour_q <= Time_Read_Data;
                    default: ;
                endcase
            end
            if (state_q == StUpdate) begin
                hour_q  <= sh_hour_q & HourMask;
                min_q   <= sh_min_q & MinMask;
                sec_q   <= sh_sec_q & SecMask;
                valid_q <= 1'b1;
                err_q   <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Start_Sig       = start_sig_q;
    assign Time_Write_Data = wdata_q;
    assign Hour            = hour_q;
    assign Min             = min_q;
    assign Sec             = sec_q;
    assign Time_Valid      = valid_q;
    assign Err             = err_q;
    assign Busy            = (state_q != StIdle);

endmodule

// File: tb/tb_rtc_poll_ctrl.sv
// Directed bench for rtc_poll_ctrl with a behavioural DS1302 access-block model.
module tb_rtc_poll_ctrl;

    localparam int unsigned POLL = 40;
    localparam int unsigned TMO  = 30;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       Set_Req = 1'b0;
    logic [7:0] Set_Hour = '0, Set_Min = '0, Set_Sec = '0;
    logic [7:0] Start_Sig;
    logic       Done_Sig = 1'b0;
    logic [7:0] Time_Write_Data;
    logic [7:0] Time_Read_Data = '0;
    logic [7:0] Hour, Min, Sec;
    logic       Time_Valid, Busy, Err;

    int checks = 0;
    int errors = 0;

    rtc_poll_ctrl #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .Set_Req         (Set_Req),
        .Set_Hour        (Set_Hour),
        .Set_Min         (Set_Min),
        .Set_Sec         (Set_Sec),
        .Start_Sig       (Start_Sig),
        .Done_Sig        (Done_Sig),
        .Time_Write_Data (Time_Write_Data),
        .Time_Read_Data  (Time_Read_Data),
        .Hour            (Hour),
        .Min             (Min),
        .Sec             (Sec),
        .Time_Valid      (Time_Valid),
        .Busy            (Busy),
        .Err             (Err)
    );

    initial forever #5 CLK = ~CLK;

    // DS1302 model: acks each command after ack_delay cycles, stores writes, serves reads.
    int         ack_delay = 10;
    logic [7:0] no_ack_mask = '0;
    logic [7:0] model_hour = '0, model_min = '0, model_sec = '0;
    logic [7:0] sec_vals[$], min_vals[$], hour_vals[$];
    logic [15:0] cmd_log[$];
    logic [7:0] prev_start = '0;
    int         cyc = 0;
    int         gap_err = 0;
    int         snap_changes = 0;
    logic [23:0] prev_snap = '0;

    always @(negedge CLK) begin
        Done_Sig = 1'b0;
        if (!RSTn) begin
            prev_start = '0;
            cyc = 0;
        end else begin
            if (Start_Sig != 8'h00) begin
                if (Start_Sig != prev_start) begin
                    if (prev_start != 8'h00) gap_err++;
                    cmd_log.push_back({Start_Sig, Time_Write_Data});
                    cyc = 0;
                end
                cyc++;
                if (cyc == ack_delay && (Start_Sig & no_ack_mask) == 8'h00) begin
                    Done_Sig = 1'b1;
                    case (Start_Sig)
                        8'h40: model_hour = Time_Write_Data;
                        8'h20: model_min = Time_Write_Data;
                        8'h10: model_sec = Time_Write_Data;
                        8'h01: Time_Read_Data = (sec_vals.size() > 0) ? sec_vals.pop_front() : model_sec;
                        8'h02: Time_Read_Data = (min_vals.size() > 0) ? min_vals.pop_front() : model_min;
                        8'h04: Time_Read_Data = (hour_vals.size() > 0) ? hour_vals.pop_front() : model_hour;
                        default: ;
                    endcase
                end
            end
            prev_start = Start_Sig;
        end
        if ({Hour, Min, Sec} != prev_snap) snap_changes++;
        prev_snap = {Hour, Min, Sec};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_log[$];

    task automatic push_exp(input logic [7:0] cmd, input logic [7:0] data);
        exp_log.push_back({cmd, data});
    endtask

    task automatic push_reads();
        push_exp(8'h01, 8'h00);
        push_exp(8'h02, 8'h00);
        push_exp(8'h04, 8'h00);
`ifdef RTC_COHERENT_READ_EN
        push_exp(8'h01, 8'h00);
`endif
    endtask

    task automatic push_writes(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        push_exp(8'h80, 8'h00);
        push_exp(8'h40, h);
        push_exp(8'h20, m);
        push_exp(8'h10, s);
        push_exp(8'h08, 8'h80);
    endtask

    task automatic check_log(input string tag);
        int n;
        check_eq($sformatf("%s_len", tag), cmd_log.size(), exp_log.size());
        n = (cmd_log.size() < exp_log.size()) ? cmd_log.size() : exp_log.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_cmd%0d", tag, i), cmd_log[i][15:8], exp_log[i][15:8]);
            if ((exp_log[i][15:8] & 8'hF8) != 8'h00)
                check_eq($sformatf("%s_data%0d", tag, i), cmd_log[i][7:0], exp_log[i][7:0]);
        end
        check_eq($sformatf("%s_gap", tag), gap_err, 0);
        cmd_log.delete();
        exp_log.delete();
    endtask

    // Returns the number of idle cycles seen before Busy rose.
    task automatic wait_busy(input string tag, output int idle_n);
        bit ok = 1'b0;
        idle_n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (Busy) begin
                ok = 1'b1;
                break;
            end
            idle_n++;
        end
        check_eq({tag, "_busy"}, ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_idle"}, ok, 1);
    endtask

    task automatic wait_start(input string tag, input logic [7:0] val);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (Start_Sig == val) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_start"}, ok, 1);
    endtask

    task automatic pulse_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        Set_Req = 1'b1;
        Set_Hour = h;
        Set_Min = m;
        Set_Sec = s;
        @(negedge CLK);
        Set_Req = 1'b0;
        Set_Hour = 8'hAA;
        Set_Min = 8'hAA;
        Set_Sec = 8'hAA;
    endtask

    task automatic check_snap(input string tag, input logic [23:0] exp);
        check_eq({tag, "_snap"}, {Hour, Min, Sec}, exp);
    endtask

    initial begin
        int n;
        // 1: reset state, then init write sequence and first read
        repeat (3) @(negedge CLK);
        check_eq("rst_start", Start_Sig, 8'h00);
        check_eq("rst_wdata", Time_Write_Data, 8'h00);
        check_eq("rst_flags", {Busy, Time_Valid, Err}, 3'b000);
        check_snap("rst", 24'h000000);
        RSTn = 1'b1;
        wait_busy("init", n);
        wait_idle("init");
        push_writes(8'h12, 8'h00, 8'h00);
        push_reads();
        check_log("init");
        check_snap("init", 24'h120000);
        check_eq("init_valid", Time_Valid, 1'b1);

        // 2: poll interval and masked single-cycle update
        model_sec = 8'hD9;
        model_min = 8'h59;
        model_hour = 8'h93;
        snap_changes = 0;
        wait_busy("poll", n);
        check_eq("poll_interval", n + 1, POLL);
        check_eq("poll_hold_snap", {Hour, Min, Sec}, 24'h120000);
        wait_idle("poll");
        push_reads();
        check_log("poll");
        check_snap("poll", 24'h135959);
        check_eq("poll_one_change", snap_changes, 1);
        check_eq("poll_flags", {Time_Valid, Err}, 2'b10);

        // 3: two set requests during a read; the last one is written afterwards
        wait_busy("set", n);
        wait_start("set", 8'h02);
        pulse_set(8'h01, 8'h02, 8'h03);
        @(negedge CLK);
        pulse_set(8'h23, 8'h45, 8'h30);
        check_eq("set_busy_mid", Busy, 1'b1);
        wait_idle("set_rd");
        wait_busy("set_wr", n);
        wait_idle("set_wr");
        push_reads();
        push_writes(8'h23, 8'h45, 8'h30);
        push_reads();
        check_log("set");
        check_snap("set", 24'h234530);

        // 4: minute read never acked -> timeout
        no_ack_mask = 8'h02;
        wait_busy("tmo", n);
        wait_start("tmo", 8'h02);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (Start_Sig != 8'h02) break;
            n++;
        end
        check_eq("tmo_len", n, TMO);
        check_eq("tmo_start_drop", Start_Sig, 8'h00);
        check_eq("tmo_flags", {Busy, Err, Time_Valid}, 3'b011);
        check_snap("tmo", 24'h234530);
        no_ack_mask = 8'h00;
        cmd_log.delete();
        wait_busy("tmo_recover", n);
        check_eq("tmo_err_held", Err, 1'b1);
        wait_idle("tmo_recover");
        check_eq("tmo_err_clr", Err, 1'b0);
        check_snap("tmo_recover", 24'h234530);
        push_reads();
        check_log("tmo_recover");

`ifdef RTC_COHERENT_READ_EN
        // 5: seconds wrap across the hour read forces one full re-read
        sec_vals = '{8'h59, 8'h00, 8'h00, 8'h01};
        min_vals = '{8'h59, 8'h00};
        hour_vals = '{8'h13, 8'h14};
        wait_busy("coh", n);
        wait_idle("coh");
        push_reads();
        push_reads();
        check_log("coh");
        check_snap("coh", 24'h140000);
`endif

        // 6: reset in the middle of the hour read
        wait_busy("rst2", n);
        wait_start("rst2", 8'h04);
        RSTn = 1'b0;
        @(negedge CLK);
        check_eq("rst2_start", Start_Sig, 8'h00);
        check_eq("rst2_flags", {Busy, Time_Valid, Err}, 3'b000);
        check_snap("rst2", 24'h000000);
        RSTn = 1'b1;
        @(negedge CLK);
        check_eq("rst2_reinit", Start_Sig, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
